// File: rtl/hangman_ctrl_if.sv
// Control/status bundle between the hangman round controller and its keypad/datapath.
interface hangman_ctrl_if;
    logic       start, key_enter, key_done, guess_valid;
    logic       gallows_done, dash_done, fill_done, part_done;
    logic       match, word_complete;
    logic       ld, ld_g, dash_en, compare, fill, draw, timecount;
    logic       p1_point, p2_point;
    logic [4:0] word_len;
    logic [3:0] wrong_cnt;
    logic [3:0] state;

    modport slave (
        input  start, key_enter, key_done, guess_valid,
               gallows_done, dash_done, fill_done, part_done, match, word_complete,
        output ld, ld_g, dash_en, compare, fill, draw, timecount,
               p1_point, p2_point, word_len, wrong_cnt, state
    );

    modport master (
        output start, key_enter, key_done, guess_valid,
               gallows_done, dash_done, fill_done, part_done, match, word_complete,
        input  ld, ld_g, dash_en, compare, fill, draw, timecount,
               p1_point, p2_point, word_len, wrong_cnt, state
    );
endinterface

// File: rtl/hangman_ctrl.sv
// Round sequencer for a two-player hangman game: word entry, drawing, guessing, scoring.
module hangman_ctrl #(
    parameter int MAX_LEN     = 16,
    parameter int MAX_PARTS   = 9,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic           clk,
    input  logic           resetn,
    hangman_ctrl_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,  LOAD  = 4'd1,  GALLOWS = 4'd2,  DASHES = 4'd3,
        WAIT    = 4'd4,  COMPARE = 4'd5, EVAL  = 4'd6,   FILL   = 4'd7,
        PART    = 4'd8,  P1WIN = 4'd9,  P2WIN   = 4'd10, OVER   = 4'd11
    } state_e;

    typedef struct packed {
        logic ld, ld_g, dash_en, compare, fill, draw, timecount, p1_point, p2_point;
    } outs_t;

    state_e        state_q, state_d;
    logic [4:0]    word_len_q, word_len_d;
    logic [3:0]    wrong_cnt_q, wrong_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    outs_t         outs_q, outs_d;

    always_comb begin
        state_d     = state_q;
        word_len_d  = word_len_q;
        wrong_cnt_d = wrong_cnt_q;
        timer_d     = timer_q;
        outs_d      = '0;

        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d     = LOAD;
                    word_len_d  = '0;
                    wrong_cnt_d = '0;
                    timer_d     = '0;
                end
            end
            LOAD: begin
                // An enter in the same cycle as done wins; done is dropped.
                if (bus.key_enter) begin
                    if (word_len_q < 5'(MAX_LEN)) begin
                        outs_d.ld  = 1'b1;
                        word_len_d = word_len_q + 5'd1;
                    end
                end else if (bus.key_done && word_len_q != 5'd0) begin
                    state_d = GALLOWS;
                end
            end
            GALLOWS: if (bus.gallows_done) state_d = DASHES;
            DASHES:  if (bus.dash_done)    state_d = WAIT;
            WAIT: begin
                if (bus.guess_valid)                      state_d = COMPARE;
                else if (timer_q == TW'(TIMEOUT_CYC - 1)) state_d = P1WIN;
                else                                      timer_d = timer_q + 1'b1;
            end
            COMPARE: state_d = EVAL;
            EVAL:    state_d = bus.match ? FILL : PART;
            FILL: begin
                if (bus.fill_done) state_d = bus.word_complete ? P2WIN : WAIT;
            end
            PART: begin
                if (bus.part_done) begin
                    if (wrong_cnt_q < 4'(MAX_PARTS)) wrong_cnt_d = wrong_cnt_q + 4'd1;
                    state_d = (wrong_cnt_q + 4'd1 >= 4'(MAX_PARTS)) ? P1WIN : WAIT;
                end
            end
            P1WIN, P2WIN: state_d = OVER;
            default:      state_d = IDLE;
        endcase

        // Every guess gets a fresh time budget.
        if (state_d == WAIT && state_q != WAIT) timer_d = '0;

        // Held enables track the state they belong to, registered alongside it.
        outs_d.ld_g      = (state_d == GALLOWS);
        outs_d.dash_en   = (state_d == DASHES);
        outs_d.compare   = (state_d == COMPARE);
        outs_d.fill      = (state_d == FILL);
        outs_d.draw      = (state_d == PART);
        outs_d.timecount = (state_d == WAIT);
        outs_d.p1_point  = (state_d == P1WIN);
        outs_d.p2_point  = (state_d == P2WIN);
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q     <= IDLE;
            word_len_q  <= '0;
            wrong_cnt_q <= '0;
            timer_q     <= '0;
            outs_q      <= '0;
        end else begin
            state_q     <= state_d;
            word_len_q  <= word_len_d;
            wrong_cnt_q <= wrong_cnt_d;
            timer_q     <= timer_d;
            outs_q      <= outs_d;
        end
    end

    assign bus.ld        = outs_q.ld;
    assign bus.ld_g      = outs_q.ld_g;
    assign bus.dash_en   = outs_q.dash_en;
    assign bus.compare   = outs_q.compare;
    assign bus.fill      = outs_q.fill;
    assign bus.draw      = outs_q.draw;
    assign bus.timecount = outs_q.timecount;
    assign bus.p1_point  = outs_q.p1_point;
    assign bus.p2_point  = outs_q.p2_point;
    assign bus.word_len  = word_len_q;
    assign bus.wrong_cnt = wrong_cnt_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_hangman_ctrl.sv
// Directed plus randomized-game bench for hangman_ctrl; the bench plays keypad and datapath.
module tb_hangman_ctrl;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    hangman_ctrl_if hif();

    hangman_ctrl #(.MAX_LEN(16), .MAX_PARTS(9), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .resetn(resetn), .bus(hif.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Cycle-level event counters sampled mid-cycle.
    int   ld_cnt = 0, p1_cnt = 0, p2_cnt = 0, draw_ent = 0, multi_en = 0;
    logic draw_prev = 1'b0;
    always @(negedge clk) begin
        if (hif.ld)                    ld_cnt   <= ld_cnt + 1;
        if (hif.p1_point)              p1_cnt   <= p1_cnt + 1;
        if (hif.p2_point)              p2_cnt   <= p2_cnt + 1;
        if (hif.draw && !draw_prev)    draw_ent <= draw_ent + 1;
        if ($countones({hif.ld, hif.ld_g, hif.dash_en, hif.compare, hif.fill, hif.draw}) > 1)
            multi_en <= multi_en + 1;
        draw_prev <= hif.draw;
    end

    typedef enum {P_START, P_ENTER, P_DONE, P_GUESS, P_GAL, P_DASH, P_FILL, P_PART} pin_e;

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_pin(input pin_e p, input logic v);
        case (p)
            P_START: hif.start        = v;
            P_ENTER: hif.key_enter    = v;
            P_DONE:  hif.key_done     = v;
            P_GUESS: hif.guess_valid  = v;
            P_GAL:   hif.gallows_done = v;
            P_DASH:  hif.dash_done    = v;
            P_FILL:  hif.fill_done    = v;
            default: hif.part_done    = v;
        endcase
    endtask

    task automatic pulse(input pin_e p);
        set_pin(p, 1'b1); tick(); set_pin(p, 1'b0);
    endtask

    function automatic logic [31:0] all_outs();
        return {hif.ld, hif.ld_g, hif.dash_en, hif.compare, hif.fill, hif.draw,
                hif.timecount, hif.p1_point, hif.p2_point};
    endfunction

    // From IDLE/OVER to the first WAIT cycle with a word of len characters.
    task automatic begin_round(input int len);
        pulse(P_START);
        chk("start->LOAD", hif.state, 1);
        repeat (len) pulse(P_ENTER);
        pulse(P_DONE);
        chk("done->GALLOWS", {hif.state, hif.ld_g}, {4'd2, 1'b1});
        repeat ($urandom_range(0, 2)) tick();
        pulse(P_GAL);
        chk("gallows->DASHES", {hif.state, hif.ld_g, hif.dash_en}, {4'd3, 1'b0, 1'b1});
        repeat ($urandom_range(0, 2)) tick();
        pulse(P_DASH);
        chk("dashes->WAIT", {hif.state, hif.dash_en, hif.timecount}, {4'd4, 1'b0, 1'b1});
    endtask

    // One guess from WAIT through FILL or PART; returns just after the exit edge.
    task automatic do_guess(input logic m, input logic wc);
        pulse(P_GUESS);
        chk("guess->COMPARE", {hif.state, hif.compare}, {4'd5, 1'b1});
        hif.match = m;
        tick();
        chk("EVAL", {hif.state, hif.compare}, {4'd6, 1'b0});
        tick();
        if (m) begin
            chk("FILL", {hif.state, hif.fill, hif.draw}, {4'd7, 1'b1, 1'b0});
            repeat ($urandom_range(0, 2)) tick();
            chk("fill held", hif.fill, 1);
            hif.word_complete = wc;
            pulse(P_FILL);
            hif.word_complete = 1'b0;
        end else begin
            chk("PART", {hif.state, hif.draw, hif.fill}, {4'd8, 1'b1, 1'b0});
            repeat ($urandom_range(0, 2)) tick();
            chk("draw held", hif.draw, 1);
            pulse(P_PART);
        end
        hif.match = 1'b0;
    endtask

    initial begin
        int base, b1, b2, bd, n;
        {hif.start, hif.key_enter, hif.key_done, hif.guess_valid} = '0;
        {hif.gallows_done, hif.dash_done, hif.fill_done, hif.part_done} = '0;
        {hif.match, hif.word_complete} = '0;

        // Reset state
        #2 resetn = 1'b1;
        #1;
        chk("reset state", hif.state, 0);
        chk("reset outs", all_outs(), 0);
        chk("reset counts", {hif.word_len, hif.wrong_cnt}, 0);
        tick(); tick();
        resetn = 1'b0;
        tick();
        chk("idle after release", hif.state, 0);

        // Load round with three characters
        base = ld_cnt;
        pulse(P_START);
        chk("start->LOAD", hif.state, 1);
        repeat (3) pulse(P_ENTER);
        tick();
        chk("three ld pulses", ld_cnt - base, 3);
        chk("word_len=3", hif.word_len, 3);
        pulse(P_DONE);
        chk("GALLOWS", {hif.state, hif.ld_g}, {4'd2, 1'b1});
        tick(); tick();
        chk("ld_g held", {hif.state, hif.ld_g, hif.dash_en}, {4'd2, 1'b1, 1'b0});
        pulse(P_GAL);
        tick();
        chk("dash_en held", {hif.state, hif.ld_g, hif.dash_en}, {4'd3, 1'b0, 1'b1});
        pulse(P_DASH);
        chk("WAIT reached", {hif.state, hif.timecount}, {4'd4, 1'b1});

        // Foreign completion pulses and start are ignored in WAIT
        hif.start = 1; hif.gallows_done = 1; hif.dash_done = 1; hif.fill_done = 1; hif.part_done = 1;
        tick();
        hif.start = 0; hif.gallows_done = 0; hif.dash_done = 0; hif.fill_done = 0; hif.part_done = 0;
        chk("stray pulses ignored", {hif.state, hif.wrong_cnt, hif.word_len}, {4'd4, 4'd0, 5'd3});

        // Correct guess completing the word
        b2 = p2_cnt;
        do_guess(1'b1, 1'b1);
        chk("P2WIN", {hif.state, hif.p2_point}, {4'd10, 1'b1});
        tick();
        chk("OVER after P2WIN", {hif.state, hif.p2_point}, {4'd11, 1'b0});
        chk("one p2 pulse", p2_cnt - b2, 1);

        // Nine wrong guesses
        b1 = p1_cnt; bd = draw_ent;
        pulse(P_START);
        chk("OVER start clears", {hif.state, hif.word_len, hif.wrong_cnt}, {4'd1, 5'd0, 4'd0});
        tick();
        begin_round(2);
        for (int i = 0; i < 9; i++) begin
            do_guess(1'b0, 1'b0);
            chk("wrong_cnt step", hif.wrong_cnt, i + 1);
            chk("post-part state", hif.state, (i == 8) ? 9 : 4);
        end
        tick();
        tick();
        chk("OVER after 9 wrong", {hif.state, hif.draw, hif.wrong_cnt}, {4'd11, 1'b0, 4'd9});
        chk("one p1 pulse", p1_cnt - b1, 1);
        chk("nine draws only", draw_ent - bd, 9);

        // Timeout with no guess
        b1 = p1_cnt;
        begin_round(1);
        n = 0;
        while (!hif.p1_point && n < 20) begin tick(); n++; end
        chk("timeout latency", n, TO);
        tick();
        chk("OVER after timeout", {hif.state, hif.timecount}, {4'd11, 1'b0});
        chk("timeout p1 pulse", p1_cnt - b1, 1);

        // Load boundaries
        base = ld_cnt;
        pulse(P_START);
        pulse(P_DONE);
        chk("empty done ignored", {hif.state, hif.word_len}, {4'd1, 5'd0});
        hif.key_enter = 1; hif.key_done = 1;
        tick();
        hif.key_enter = 0; hif.key_done = 0;
        chk("enter+done", {hif.state, hif.ld, hif.word_len}, {4'd1, 1'b1, 5'd1});
        repeat (16) pulse(P_ENTER);
        chk("17th enter no ld", hif.ld, 0);
        chk("word_len saturates", hif.word_len, 16);
        chk("sixteen ld total", ld_cnt - base, 16);
        pulse(P_DONE);
        pulse(P_GAL);
        pulse(P_DASH);
        chk("WAIT for expiry test", hif.state, 4);

        // Guess in the timeout cycle wins
        b1 = p1_cnt;
        repeat (TO - 1) tick();
        chk("still WAIT at expiry", {hif.state, hif.timecount}, {4'd4, 1'b1});
        pulse(P_GUESS);
        chk("expiry guess->COMPARE", hif.state, 5);
        hif.match = 1'b1;
        tick(); tick();
        chk("in FILL", {hif.state, hif.fill}, {4'd7, 1'b1});
        tick();
        chk("no p1 on expiry guess", p1_cnt - b1, 0);

        // Asynchronous reset in FILL
        b2 = p2_cnt;
        hif.word_complete = 1'b1; hif.fill_done = 1'b1;
        resetn = 1'b1;
        #1;
        chk("async reset state", hif.state, 0);
        chk("async reset outs", all_outs(), 0);
        tick(); tick();
        hif.word_complete = 1'b0; hif.fill_done = 1'b0; hif.match = 1'b0;
        resetn = 1'b0;
        tick();
        chk("no p2 after reset", p2_cnt - b2, 0);
        pulse(P_START);
        chk("start after reset", {hif.state, hif.word_len, hif.wrong_cnt}, {4'd1, 5'd0, 4'd0});
        resetn = 1'b1; tick(); resetn = 1'b0; tick();

        // Random games against a game-rule model
        for (int g = 0; g < 8; g++) begin
            int len, wrong, win, ng;
            int word[$];
            int perm[12];
            logic [11:0] need, seen;
            len = $urandom_range(1, 4);
            need = '0;
            for (int k = 0; k < len; k++) begin
                word.push_back($urandom_range(0, 11));
                need[word[k]] = 1'b1;
            end
            for (int k = 0; k < 12; k++) perm[k] = k;
            for (int k = 11; k > 0; k--) begin
                int j, t;
                j = $urandom_range(0, k);
                t = perm[k]; perm[k] = perm[j]; perm[j] = t;
            end
            wrong = 0; win = 0; ng = 0; seen = '0;
            for (int k = 0; k < 12 && win == 0; k++) begin
                ng++;
                if (need[perm[k]]) begin
                    seen[perm[k]] = 1'b1;
                    if (seen == need) win = 2;
                end else begin
                    wrong++;
                    if (wrong == 9) win = 1;
                end
            end

            b1 = p1_cnt; b2 = p2_cnt;
            begin_round(len);
            seen = '0;
            for (int k = 0; k < ng; k++) begin
                logic m;
                m = need[perm[k]];
                if (m) seen[perm[k]] = 1'b1;
                do_guess(m, m && (seen == need));
                if (k < ng - 1) chk("game mid WAIT", hif.state, 4);
            end
            chk("game winner state", hif.state, 8 + win);
            tick();
            chk("game OVER", hif.state, 11);
            chk("game p1 count", p1_cnt - b1, (win == 1) ? 1 : 0);
            chk("game p2 count", p2_cnt - b2, (win == 2) ? 1 : 0);
            chk("game wrong_cnt", hif.wrong_cnt, wrong);
            chk("game word_len", hif.word_len, len);
        end

        tick();
        chk("datapath enables exclusive", multi_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
